// File: rtl/freq_pkg.sv
// Shared types and constants for the period-to-frequency converter.
package freq_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 32'd50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // What the DONE state should publish once it is reached.
  typedef enum logic [1:0] {
    RES_NORMAL  = 2'd0,
    RES_DIVZERO = 2'd1,
    RES_LOST    = 2'd2
  } result_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
module seq_divider
  import freq_pkg::*;
#(
  parameter int DVD_W = 26,
  parameter int DVS_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             done_o,
  output logic [DVD_W-1:0] quotient_o
);

  localparam int CNT_W = $clog2(DVD_W + 1);
  localparam int REM_W = DVS_W + 1;

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DVD_W-1:0] dvd_q, dvd_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [DVD_W-1:0] quo_q, quo_d;

  logic [REM_W:0]   shift_s;
  logic             fits_s;
  logic             last_s;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    shift_s = {rem_q, dvd_q[DVD_W-1]};
    fits_s  = (shift_s >= {2'b00, dvs_q});
    last_s  = run_q && (cnt_q == CNT_W'(DVD_W - 1));
  end

  // done_o is high in the cycle whose closing edge writes the final quotient bit.
  assign done_o     = last_s;
  assign quotient_o = quo_q;

  // Next-state: load on start, iterate while running, drop on abort.
  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    quo_d = quo_q;
    if (abort_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      run_d = 1'b1;
      cnt_d = '0;
      dvd_d = dividend_i;
      dvs_d = divisor_i;
      rem_d = '0;
      quo_d = '0;
    end else if (run_q) begin
      dvd_d = {dvd_q[DVD_W-2:0], 1'b0};
      quo_d = {quo_q[DVD_W-2:0], fits_s};
      cnt_d = cnt_q + CNT_W'(1);
      if (fits_s) begin
        rem_d = REM_W'(shift_s - {2'b00, dvs_q});
      end else begin
        rem_d = REM_W'(shift_s);
      end
      if (last_s) begin
        run_d = 1'b0;
      end else begin
        run_d = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

// File: rtl/period_to_freq.sv
// Converts a measured period (in clk cycles) into a frequency in Hz, CLK_HZ/period,
// with saturation, divide-by-zero and signal-loss handling.
module period_to_freq
  import freq_pkg::*;
#(
  parameter int unsigned CLK_HZ   = CLK_HZ_DEFAULT,
  parameter int          PERIOD_W = 24,
  parameter int          FREQ_W   = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                period_valid,
  input  logic [PERIOD_W-1:0] period,
  input  logic                signal_lost,
  output logic                busy,
  output logic                freq_valid,
  output logic [FREQ_W-1:0]   frequency,
  output logic                saturated,
  output logic                divzero
);

  localparam int DIV_W = $clog2(CLK_HZ + 1);
  localparam int MAX_W = (DIV_W > FREQ_W) ? DIV_W : FREQ_W;
  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ);
  localparam logic [MAX_W-1:0] FREQ_MAX = MAX_W'({FREQ_W{1'b1}});

  state_e              state_q, state_d;
  result_e             kind_q, kind_d;
  logic                busy_q;
  logic                fvalid_q, fvalid_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic                sat_q, sat_d;
  logic                dz_q, dz_d;

  logic                div_start_s;
  logic                div_abort_s;
  logic                div_done_s;
  logic [DIV_W-1:0]    div_quo_s;
  logic [MAX_W-1:0]    quo_ext_s;
  logic                clip_s;
  logic [FREQ_W-1:0]   freq_res_s;

  seq_divider #(
    .DVD_W (DIV_W),
    .DVS_W (PERIOD_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start_s),
    .abort_i    (div_abort_s),
    .dividend_i (DIVIDEND),
    .divisor_i  (period),
    .done_o     (div_done_s),
    .quotient_o (div_quo_s)
  );

  // Clip the quotient to the output width.
  always_comb begin
    quo_ext_s = MAX_W'(div_quo_s);
    if (quo_ext_s > FREQ_MAX) begin
      clip_s     = 1'b1;
      freq_res_s = {FREQ_W{1'b1}};
    end else begin
      clip_s     = 1'b0;
      freq_res_s = quo_ext_s[FREQ_W-1:0];
    end
  end

  // FSM next-state and result selection.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    fvalid_d    = 1'b0;
    freq_d      = freq_q;
    sat_d       = sat_q;
    dz_d        = dz_q;
    div_start_s = 1'b0;
    div_abort_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (period_valid) begin
          if (signal_lost) begin
            state_d = ST_DONE;
            kind_d  = RES_LOST;
          end else if (period == {PERIOD_W{1'b0}}) begin
            state_d = ST_DONE;
            kind_d  = RES_DIVZERO;
          end else begin
            state_d     = ST_DIVIDE;
            kind_d      = RES_NORMAL;
            div_start_s = 1'b1;
          end
        end else if (signal_lost) begin
          freq_d = {FREQ_W{1'b0}};
          sat_d  = 1'b0;
          dz_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIVIDE: begin
        // Signal loss wins over a divider finishing on the same edge.
        if (signal_lost) begin
          state_d     = ST_DONE;
          kind_d      = RES_LOST;
          div_abort_s = 1'b1;
        end else if (div_done_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DIVIDE;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        fvalid_d = 1'b1;
        case (kind_q)
          RES_NORMAL: begin
            freq_d = freq_res_s;
            sat_d  = clip_s;
            dz_d   = 1'b0;
          end
          RES_DIVZERO: begin
            freq_d = {FREQ_W{1'b0}};
            sat_d  = 1'b0;
            dz_d   = 1'b1;
          end
          default: begin
            freq_d = {FREQ_W{1'b0}};
            sat_d  = 1'b0;
            dz_d   = 1'b0;
          end
        endcase
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      kind_q   <= RES_NORMAL;
      busy_q   <= 1'b0;
      fvalid_q <= 1'b0;
      freq_q   <= {FREQ_W{1'b0}};
      sat_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      busy_q   <= (state_d != ST_IDLE);
      fvalid_q <= fvalid_d;
      freq_q   <= freq_d;
      sat_q    <= sat_d;
      dz_q     <= dz_d;
    end
  end

  assign busy       = busy_q;
  assign freq_valid = fvalid_q;
  assign frequency  = freq_q;
  assign saturated  = sat_q;
  assign divzero    = dz_q;

endmodule

// File: tb/tb_period_to_freq.sv
// Scoreboard bench for period_to_freq: a cycle-level reference model queues
// expected results, a monitor pops them on freq_valid.
module tb_period_to_freq;

  localparam int unsigned CLK_HZ   = 50_000_000;
  localparam int          PERIOD_W = 24;
  localparam int          FREQ_W   = 20;
  localparam int          DIV_W    = $clog2(CLK_HZ + 1);
  localparam longint      FREQ_MAX = (64'd1 << FREQ_W) - 64'd1;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                period_valid;
  logic [PERIOD_W-1:0] period;
  logic                signal_lost;
  logic                busy;
  logic                freq_valid;
  logic [FREQ_W-1:0]   frequency;
  logic                saturated;
  logic                divzero;

  period_to_freq #(
    .CLK_HZ   (CLK_HZ),
    .PERIOD_W (PERIOD_W),
    .FREQ_W   (FREQ_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .period_valid (period_valid),
    .period       (period),
    .signal_lost  (signal_lost),
    .busy         (busy),
    .freq_valid   (freq_valid),
    .frequency    (frequency),
    .saturated    (saturated),
    .divzero      (divzero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     due;
    longint freq;
    bit     sat;
    bit     dz;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  bit     m_busy = 1'b0;
  bit     m_inflight = 1'b0;
  bit     m_can_abort = 1'b0;
  int     m_div_end = 0;
  longint h_freq = 0;
  bit     h_sat = 1'b0;
  bit     h_dz = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: decides acceptance and results from the rules, edge by edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        if (m_inflight && sb.size() > 0) sb.delete(sb.size() - 1);
        m_busy = 1'b0; m_inflight = 1'b0; m_can_abort = 1'b0;
        h_freq = 0; h_sat = 1'b0; h_dz = 1'b0;
      end else begin
        cyc++;
        if (m_busy) begin
          if (m_can_abort && cyc <= m_div_end && signal_lost) begin
            exp_t e;
            e = sb[sb.size() - 1];
            e.due = cyc + 1; e.freq = 0; e.sat = 1'b0; e.dz = 1'b0;
            sb[sb.size() - 1] = e;
            m_can_abort = 1'b0;
          end else if (sb.size() > 0 && cyc == sb[sb.size() - 1].due) begin
            h_freq = sb[sb.size() - 1].freq;
            h_sat  = sb[sb.size() - 1].sat;
            h_dz   = sb[sb.size() - 1].dz;
            m_busy = 1'b0; m_inflight = 1'b0; m_can_abort = 1'b0;
          end
        end else if (period_valid) begin
          exp_t   e;
          longint q;
          if (signal_lost) begin
            e = '{cyc + 1, 0, 1'b0, 1'b0};
            m_can_abort = 1'b0;
          end else if (period == 0) begin
            e = '{cyc + 1, 0, 1'b0, 1'b1};
            m_can_abort = 1'b0;
          end else begin
            q = longint'(CLK_HZ) / longint'(period);
            if (q > FREQ_MAX) e = '{cyc + DIV_W + 1, FREQ_MAX, 1'b1, 1'b0};
            else              e = '{cyc + DIV_W + 1, q, 1'b0, 1'b0};
            m_can_abort = 1'b1;
            m_div_end   = cyc + DIV_W;
          end
          sb.push_back(e);
          m_busy = 1'b1; m_inflight = 1'b1;
        end else if (signal_lost) begin
          h_freq = 0; h_sat = 1'b0; h_dz = 1'b0;
        end
      end
    end
  end

  // Monitor: compares DUT outputs on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("outputs_in_reset", {busy, freq_valid, saturated, divzero, frequency}, 0);
      end else begin
        if (freq_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_valid", freq_valid, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("result_cycle", cyc, e.due);
            check("frequency", frequency, e.freq);
            check("saturated", saturated, e.sat);
            check("divzero", divzero, e.dz);
          end
        end else if (sb.size() > 0 && cyc >= sb[0].due) begin
          check("missing_valid", freq_valid, 1);
          void'(sb.pop_front());
        end
        check("held_frequency", frequency, h_freq);
        check("held_flags", {saturated, divzero}, {h_sat, h_dz});
        check("busy", busy, m_busy);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_busy) check("idle_timeout", m_busy, 0);
  endtask

  task automatic send(input logic [PERIOD_W-1:0] p);
    wait_idle();
    period = p;
    period_valid = 1'b1;
    @(posedge clk); #1;
    period_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; period_valid = 1'b0; signal_lost = 1'b0; period = '0;
    #2;
    check("reset_busy", busy, 0);
    check("reset_frequency", frequency, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send(24'd50_000);
    send(24'd48);
    send(24'd47);
    send(24'd0);
    send(24'd16_777_215);

    // Signal loss mid-division, with a period_valid that must be ignored.
    send(24'd1000);
    repeat (9) @(posedge clk);
    #1 signal_lost = 1'b1; period_valid = 1'b1; period = 24'd5;
    @(posedge clk); #1;
    signal_lost = 1'b0; period_valid = 1'b0;

    // Signal loss at accept time, then loss while idle after a valid result.
    wait_idle();
    signal_lost = 1'b1; period_valid = 1'b1; period = 24'd777;
    @(posedge clk); #1;
    signal_lost = 1'b0; period_valid = 1'b0;
    send(24'd5000);
    wait_idle();
    signal_lost = 1'b1;
    @(posedge clk); #1;
    signal_lost = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a division; accept on the first edge after release.
    send(24'd1000);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_busy", busy, 0);
    check("async_reset_frequency", frequency, 0);
    period_valid = 1'b1; period = 24'd3000;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("accept_after_reset", busy, 1);
    period_valid = 1'b0;

    // Back-to-back stream.
    wait_idle();
    period_valid = 1'b1; period = 24'd25_000;
    repeat (28 * 4) @(posedge clk);
    #1 period_valid = 1'b0;

    // Randomised traffic.
    repeat (3000) begin
      @(posedge clk); #1;
      period_valid = ($urandom % 3) == 0;
      signal_lost  = ($urandom % 50) == 0;
      case ($urandom % 4)
        0:       period = PERIOD_W'($urandom_range(0, 60));
        1:       period = PERIOD_W'($urandom_range(40, 60000));
        default: period = PERIOD_W'($urandom);
      endcase
    end
    #1 period_valid = 1'b0; signal_lost = 1'b0;

    begin
      int n;
      n = 0;
      while ((m_busy || sb.size() > 0) && n < 100) begin
        @(posedge clk);
        n++;
      end
      @(negedge clk);
      check("drain_pending", sb.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
